// File: rtl/sra_pipe.sv
// sra_pipe: pipelined 32-bit right shifter (SRL / SRA, optional rotate-right).
//
// One register stage per shift-amount bit. Stage k applies the 2**k shift when
// shamt bit k is set, so an op spends SHW cycles in the pipe and a new op can
// enter every cycle. Valid/ready handshake on both sides; stalls collapse
// bubbles from the output backwards.
//
// Optional feature: define SRA_PIPE_ROR_EN to add ctrl_rotate (rotate-right,
// overrides ctrl_arith) and widen the per-stage mode register to 2 bits.
//
// Ports:
//   clock          in   1      rising-edge clock
//   reset_n        in   1      asynchronous reset, active low
//   data_operandA  in   WIDTH  operand to shift
//   ctrl_shiftamt  in   SHW    shift amount 0..WIDTH-1
//   ctrl_arith     in   1      1 = SRA (sign fill), 0 = SRL (zero fill)
//   ctrl_rotate    in   1      (SRA_PIPE_ROR_EN only) 1 = rotate right
//   in_valid       in   1      input op present
//   in_ready       out  1      stage 0 can accept this cycle
//   data_result    out  WIDTH  shifted result (last stage register)
//   out_valid      out  1      data_result holds a completed op
//   out_ready      in   1      consumer takes result this cycle

module sra_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [SHW-1:0]   ctrl_shiftamt,
  input  logic             ctrl_arith,
`ifdef SRA_PIPE_ROR_EN
  input  logic             ctrl_rotate,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             out_valid,
  input  logic             out_ready
);

  // Mode bits: bit 0 = arithmetic fill, bit 1 = rotate (when present).
`ifdef SRA_PIPE_ROR_EN
  localparam int MW = 2;
`else
  localparam int MW = 1;
`endif

  logic [SHW-1:0]   v_q;
  logic [SHW-1:0]   v_d;
  logic [WIDTH-1:0] d_q [SHW];
  logic [WIDTH-1:0] d_d [SHW];
  logic [SHW-1:0]   s_q [SHW];
  logic [SHW-1:0]   s_d [SHW];
  logic [MW-1:0]    m_q [SHW];
  logic [MW-1:0]    m_d [SHW];

  logic [SHW-1:0]   adv;
  logic [SHW-1:0]   ld;
  logic [MW-1:0]    mode_in;
  logic             accept;

`ifdef SRA_PIPE_ROR_EN
  // Rotate wins over arithmetic, so the arith bit is cleared for rotates.
  assign mode_in = {ctrl_rotate, ctrl_arith & ~ctrl_rotate};
`else
  assign mode_in = ctrl_arith;
`endif

  // Shift right by sh with fill chosen from the incoming data of this stage.
  function automatic logic [WIDTH-1:0] stage_shift(
    input logic [WIDTH-1:0] din,
    input logic [MW-1:0]    mode,
    input int unsigned      sh
  );
    logic [WIDTH-1:0] top_mask;
    logic [WIDTH-1:0] fill;
    top_mask = ~({WIDTH{1'b1}} >> sh);
    fill     = '0;
    if (mode[0]) fill = {WIDTH{din[WIDTH-1]}};
`ifdef SRA_PIPE_ROR_EN
    // Low sh bits wrap around to the top.
    if (mode[1]) fill = din << (WIDTH - sh);
`endif
    return (din >> sh) | (fill & top_mask);
  endfunction

  // Ready chain from the output back to stage 0; a stage may move when the
  // next one is empty or is itself moving this cycle.
  always_comb begin
    adv          = '0;
    adv[SHW-1]   = v_q[SHW-1] & out_ready;
    for (int k = SHW - 2; k >= 0; k--) begin
      adv[k] = v_q[k] & (~v_q[k+1] | adv[k+1]);
    end
  end

  assign in_ready = ~v_q[0] | adv[0];
  assign accept   = in_valid & in_ready;

  always_comb begin
    ld     = '0;
    ld[0]  = accept;
    d_d[0] = ctrl_shiftamt[0] ? stage_shift(data_operandA, mode_in, 32'd1) : data_operandA;
    s_d[0] = ctrl_shiftamt;
    m_d[0] = mode_in;
    for (int k = 1; k < SHW; k++) begin
      ld[k]  = adv[k-1];
      d_d[k] = s_q[k-1][k] ? stage_shift(d_q[k-1], m_q[k-1], 32'd1 << k) : d_q[k-1];
      s_d[k] = s_q[k-1];
      m_d[k] = m_q[k-1];
    end
    for (int k = 0; k < SHW; k++) begin
      v_d[k] = ld[k] | (v_q[k] & ~adv[k]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
      for (int k = 0; k < SHW; k++) begin
        d_q[k] <= '0;
        s_q[k] <= '0;
        m_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < SHW; k++) begin
        if (ld[k]) begin
          d_q[k] <= d_d[k];
          s_q[k] <= s_d[k];
          m_q[k] <= m_d[k];
        end
      end
    end
  end

  assign out_valid   = v_q[SHW-1];
  assign data_result = d_q[SHW-1];

endmodule

// File: tb/tb_sra_pipe.sv
// tb_sra_pipe: directed and randomized checks of sra_pipe against a
// shift/rotate reference model and an in-order expected-result queue.

module tb_sra_pipe;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [4:0]  ctrl_shiftamt = '0;
  logic        ctrl_arith = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] data_result;
  logic        rot_cur;
`ifdef SRA_PIPE_ROR_EN
  logic        ctrl_rotate = 1'b0;
  assign rot_cur = ctrl_rotate;
`else
  assign rot_cur = 1'b0;
`endif

  sra_pipe #(.WIDTH(32), .SHW(5)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .data_operandA(data_operandA),
    .ctrl_shiftamt(ctrl_shiftamt),
    .ctrl_arith   (ctrl_arith),
`ifdef SRA_PIPE_ROR_EN
    .ctrl_rotate  (ctrl_rotate),
`endif
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_result  (data_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clock = ~clock;

  int          npass = 0;
  int          nchk  = 0;
  logic [31:0] exp_q [$];

  function automatic logic [31:0] ref_shift(logic [31:0] a, int n, bit arith, bit rot);
    logic signed [31:0] sa;
    if (rot) return (n == 0) ? a : ((a >> n) | (a << (32 - n)));
    if (arith) begin
      sa = a;
      return sa >>> n;
    end
    return a >> n;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Inputs are set at a negedge; sample handshakes before the next posedge,
  // then advance to the following negedge.
  task automatic tick();
    #1;
    if (in_valid && in_ready)
      exp_q.push_back(ref_shift(data_operandA, int'(ctrl_shiftamt), ctrl_arith, rot_cur));
    if (out_valid && out_ready) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("result", data_result, exp_q.pop_front());
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_op(logic [31:0] a, logic [4:0] n, logic ar, logic ro);
    data_operandA = a;
    ctrl_shiftamt = n;
    ctrl_arith    = ar;
`ifdef SRA_PIPE_ROR_EN
    ctrl_rotate   = ro;
`endif
    in_valid      = 1'b1;
  endtask

  task automatic set_rand_op();
    logic ro;
    ro = 1'b0;
`ifdef SRA_PIPE_ROR_EN
    ro = 1'($urandom_range(0, 1));
`endif
    set_op($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), ro);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data", data_result, 0);
    chk("rst_in_ready", in_ready, 1);
    reset_n = 1'b1;
    @(negedge clock);

    // Latency: SRL 0x80000000 >> 31
    set_op(32'h8000_0000, 5'd31, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("lat_wait", out_valid, 0);
      tick();
    end
    #1;
    chk("lat_valid", out_valid, 1);
    tick();

    // Directed SRA and shamt 0
    set_op(32'h8000_0000, 5'd4, 1'b1, 1'b0); tick();
    set_op(32'h7FFF_FFF0, 5'd4, 1'b1, 1'b0); tick();
    set_op(32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0); tick();
    set_op(32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0); tick();
    in_valid = 1'b0;
    repeat (6) tick();

    // Back-to-back 8 ops at full throughput
    for (int t = 0; t < 13; t++) begin
      if (t < 8) set_rand_op(); else in_valid = 1'b0;
      #1;
      if (t < 8)  chk("b2b_in_ready", in_ready, 1);
      if (t >= 5) chk("b2b_out_valid", out_valid, 1);
      tick();
    end
    chk("b2b_drained", 32'(exp_q.size()), 0);

    // Output stall: five ops fill the pipe, sixth is refused
    out_ready = 1'b0;
    for (int t = 0; t < 6; t++) begin
      set_rand_op();
      #1;
      chk("stall_in_ready", in_ready, (t < 5) ? 1 : 0);
      tick();
    end
    in_valid = 1'b0;
    for (int t = 0; t < 3; t++) begin
      #1;
      chk("stall_out_valid", out_valid, 1);
      chk("stall_data_hold", data_result, exp_q[0]);
      tick();
    end
    out_ready = 1'b1;
    repeat (7) tick();
    chk("stall_drained", 32'(exp_q.size()), 0);

    // Async reset with ops in flight
    out_ready = 1'b0;
    set_op(32'hA5A5_A5A5, 5'd1, 1'b1, 1'b0); tick();
    set_op(32'hFFFF_0000, 5'd3, 1'b0, 1'b0); tick();
    set_op(32'h1234_5678, 5'd0, 1'b0, 1'b0); tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #1;
    chk("pre_rst_valid", out_valid, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_fly_out_valid", out_valid, 0);
    chk("rst_fly_data", data_result, 0);
    chk("rst_fly_in_ready", in_ready, 1);
    exp_q.delete();
    @(negedge clock);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      #1;
      chk("post_rst_idle", out_valid, 0);
      tick();
    end

`ifdef SRA_PIPE_ROR_EN
    // Rotate-right, overriding arith
    set_op(32'h0000_0001, 5'd1, 1'b0, 1'b1); tick();
    set_op(32'h1234_5678, 5'd8, 1'b1, 1'b1); tick();
    set_op(32'h8000_0001, 5'd31, 1'b1, 1'b1); tick();
    in_valid = 1'b0;
    repeat (6) tick();
    chk("ror_drained", 32'(exp_q.size()), 0);
`endif

    // Randomized traffic with random backpressure
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 3) != 0) set_rand_op(); else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int g = 0; g < 20 && exp_q.size() != 0; g++) tick();
    chk("rand_drained", 32'(exp_q.size()), 0);
    #1;
    chk("final_idle", out_valid, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
